// File: rtl/regwrite_arbiter.sv
// regwrite_arbiter: round-robin arbitration of the ALU (port 0) and load
// (port 1) write-back sources onto the single register-file write port.
// The winning write is registered into an output stage that freezes while
// the register file stalls. Writes to R0 are accepted but never enabled.
module regwrite_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              wb_stall,
    output logic              rf_we,
    output logic              rf_sel,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    // Index of the most recently accepted port. It resets to 1 so that the
    // first tie after reset goes to port 0.
    logic last_grant;

    // Grant decision: a port wins when it is alone or when the other port
    // won last time. Both are gated by the stall so nothing is accepted
    // while the output stage is frozen. Depends only on inputs and
    // last_grant, never on the rf_* outputs.
    always_comb begin
        req0_ready = req0_valid & ~wb_stall & (~req1_valid | last_grant);
        req1_ready = req1_valid & ~wb_stall & (~req0_valid | ~last_grant);
    end

    // Output stage and round-robin state. A stall holds everything, so a
    // pending write stays presented until the register file takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we      <= 1'b0;
            rf_sel     <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            last_grant <= 1'b1;
        end else if (!wb_stall) begin
            if (req0_ready) begin
                rf_sel     <= 1'b0;
                rf_waddr   <= req0_addr;
                rf_wdata   <= req0_data;
                rf_we      <= (req0_addr != '0);
                last_grant <= 1'b0;
            end else if (req1_ready) begin
                rf_sel     <= 1'b1;
                rf_waddr   <= req1_addr;
                rf_wdata   <= req1_data;
                rf_we      <= (req1_addr != '0);
                last_grant <= 1'b1;
            end else begin
                // Idle cycle: drop the enable, keep the last write visible.
                rf_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// tb_regwrite_arbiter: directed vector table for the arbiter plus a
// hand-written sequence for the asynchronous reset during a stall.
module tb_regwrite_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              reset;
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              wb_stall;
    logic              rf_we;
    logic              rf_sel;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    int checks   = 0;
    int failures = 0;

    regwrite_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .wb_stall   (wb_stall),
        .rf_we      (rf_we),
        .rf_sel     (rf_sel),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus: inputs applied after the falling edge, readys
    // checked before the rising edge, rf_* checked just after it.
    typedef struct {
        logic              v0;
        logic [ADDR_W-1:0] a0;
        logic [DATA_W-1:0] d0;
        logic              v1;
        logic [ADDR_W-1:0] a1;
        logic [DATA_W-1:0] d1;
        logic              stall;
        logic              e_r0;
        logic              e_r1;
        logic              e_we;
        logic              e_sel;
        logic [ADDR_W-1:0] e_waddr;
        logic [DATA_W-1:0] e_wdata;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [ADDR_W-1:0] a0,
                         input logic [DATA_W-1:0] d0, input logic v1,
                         input logic [ADDR_W-1:0] a1,
                         input logic [DATA_W-1:0] d1, input logic stall);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        wb_stall   = stall;
    endtask

    task automatic chk_out(input string tag, input logic we, input logic sel,
                           input logic [ADDR_W-1:0] wa,
                           input logic [DATA_W-1:0] wd);
        chk({tag, ".rf_we"},    {31'd0, rf_we},      {31'd0, we});
        chk({tag, ".rf_sel"},   {31'd0, rf_sel},     {31'd0, sel});
        chk({tag, ".rf_waddr"}, {27'd0, rf_waddr},   {27'd0, wa});
        chk({tag, ".rf_wdata"}, rf_wdata,            wd);
    endtask

    initial begin
        //         v0  a0  d0            v1  a1  d1            st  r0  r1  we  sel wa  wd
        vecs[0]  = '{1, 5,  32'h0000_00AA, 0, 0,  32'h0,        0,  1,  0,  1,  0,  5,  32'h0000_00AA};
        vecs[1]  = '{0, 0,  32'h0,         0, 0,  32'h0,        0,  0,  0,  0,  0,  5,  32'h0000_00AA};
        // R0 write via port 1: accepted, no enable, last_grant becomes 1
        vecs[2]  = '{0, 0,  32'h0,         1, 0,  32'hFFFF_FFFF, 0, 0,  1,  0,  1,  0,  32'hFFFF_FFFF};
        // continuous contention: 0,1,0,1
        vecs[3]  = '{1, 3,  32'h11,        1, 7,  32'h22,       0,  1,  0,  1,  0,  3,  32'h11};
        vecs[4]  = '{1, 3,  32'h11,        1, 7,  32'h22,       0,  0,  1,  1,  1,  7,  32'h22};
        vecs[5]  = '{1, 3,  32'h11,        1, 7,  32'h22,       0,  1,  0,  1,  0,  3,  32'h11};
        vecs[6]  = '{1, 3,  32'h11,        1, 7,  32'h22,       0,  0,  1,  1,  1,  7,  32'h22};
        // accept R9 on port 0, then stall three cycles with req1 pending
        vecs[7]  = '{1, 9,  32'h99,        0, 0,  32'h0,        0,  1,  0,  1,  0,  9,  32'h99};
        vecs[8]  = '{0, 0,  32'h0,         1, 12, 32'hCC,       1,  0,  0,  1,  0,  9,  32'h99};
        vecs[9]  = '{0, 0,  32'h0,         1, 12, 32'hCC,       1,  0,  0,  1,  0,  9,  32'h99};
        vecs[10] = '{0, 0,  32'h0,         1, 12, 32'hCC,       1,  0,  0,  1,  0,  9,  32'h99};
        vecs[11] = '{0, 0,  32'h0,         1, 12, 32'hCC,       0,  0,  1,  1,  1,  12, 32'hCC};
        // port 1 won last, so the tie goes to port 0
        vecs[12] = '{1, 3,  32'h11,        1, 7,  32'h22,       0,  1,  0,  1,  0,  3,  32'h11};
        vecs[13] = '{0, 0,  32'h0,         0, 0,  32'h0,        0,  0,  0,  0,  0,  3,  32'h11};

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1,
                  vecs[i].d1, vecs[i].stall);
            #1;
            chk($sformatf("v%0d.req0_ready", i), {31'd0, req0_ready}, {31'd0, vecs[i].e_r0});
            chk($sformatf("v%0d.req1_ready", i), {31'd0, req1_ready}, {31'd0, vecs[i].e_r1});
            @(posedge clk);
            #1;
            chk_out($sformatf("v%0d", i), vecs[i].e_we, vecs[i].e_sel,
                    vecs[i].e_waddr, vecs[i].e_wdata);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a stalled write.
        drive(1, 9, 32'h1234_5678, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_out("pre_rst", 1, 0, 9, 32'h1234_5678);
        @(negedge clk);
        drive(0, 0, 0, 1, 12, 32'hCC, 1);
        #2;
        reset = 1'b1;
        #1;
        chk_out("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        drive(1, 3, 32'h11, 1, 7, 32'h22, 0);
        #1;
        chk("post_rst.req0_ready", {31'd0, req0_ready}, 32'd1);
        chk("post_rst.req1_ready", {31'd0, req1_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk_out("post_rst", 1, 0, 3, 32'h11);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
